// File: rtl/bcd2bin.sv
// bcd2bin: sequential BCD-to-binary converter using reverse double-dabble, one shift per clock.
// Define BCD2BIN_ERRO_EN to add the erro output flagging invalid input digits.
module bcd2bin #(
    parameter int W = 7,
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] bcd,
    output logic [W-1:0] binary,
`ifdef BCD2BIN_ERRO_EN
    output logic         erro,
`endif
    output logic         pronto
);
    localparam int D  = N / 4;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {INICIAL, DESLOCA, FIM} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    bcd_q, bcd_d;
    logic [W-1:0]    bin_q, bin_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    binary_q, binary_d;
    logic [N+W-1:0]  sh;
    logic [N-1:0]    adj;
    logic            err;

    assign sh = {bcd_q, bin_q} >> 1;

    // Digits that reach 8 after the shift had a borrowed 10 that must become 5.
    always_comb begin
        adj = sh[N+W-1:W];
        for (int i = 0; i < D; i++)
            adj[4*i +: 4] = sh[W+4*i +: 4] >= 4'd8 ? sh[W+4*i +: 4] - 4'd3 : sh[W+4*i +: 4];
    end

`ifdef BCD2BIN_ERRO_EN
    logic erro_q, bad;
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < D; i++)
            bad = bad | (bcd[4*i +: 4] > 4'd9);
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) erro_q <= 1'b0;
        else if (state_q == INICIAL && start) erro_q <= bad;
    assign err  = erro_q;
    assign erro = erro_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= INICIAL;
            bcd_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        case (state_q)
            INICIAL: if (start) begin
                bcd_d   = bcd;
                bin_d   = '0;
                cnt_d   = '0;
                state_d = DESLOCA;
            end
            DESLOCA: if (cnt_q == CW'(W)) begin
                state_d  = FIM;
                binary_d = err ? '0 : bin_q;
            end else begin
                bcd_d = adj;
                bin_d = sh[W-1:0];
                cnt_d = cnt_q + CW'(1);
            end
            FIM:     state_d = INICIAL;
            default: state_d = INICIAL;
        endcase
    end

    always_comb begin
        pronto = state_q == FIM;
        binary = binary_q;
    end
endmodule

// File: doc/bcd2bin.md
BCD2BIN -- requirements
Module: bcd2bin

Interface
- REQ-001 SHALL have parameter W, default 7: binary result width in bits.
- REQ-002 SHALL have parameter N, default 8: BCD input width in bits; must be a multiple of 4; digit count D = N/4.
- REQ-003 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
- REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
- REQ-005 SHALL have port start  input  1  conversion request, single-cycle pulse from an external edge detector.
- REQ-006 SHALL have port bcd  input  N  packed BCD operand, least significant digit in bits [3:0].
- REQ-007 SHALL have port binary  output  W  registered unsigned binary result.
- REQ-008 SHALL have port pronto  output  1  one-cycle done pulse.

Function
- REQ-009 SHALL convert using reverse double-dabble, one shift per clock:
  - shift the {bcd_reg, bin_reg} register right by 1;
  - then subtract 3 from every BCD digit that is >= 8.
- REQ-010 SHALL implement FSM states INICIAL, DESLOCA and FIM.
- REQ-011 INICIAL: when start=1 at an edge, SHALL load bcd_reg<=bcd, bin_reg<=0 and counter<=0, then go to DESLOCA; otherwise SHALL remain in INICIAL.
- REQ-012 DESLOCA: each edge SHALL perform one shift/adjust step and increment the counter; after the W-th step it SHALL go to FIM.
- REQ-013 FIM: at entry, binary SHALL be updated from bin_reg; pronto SHALL be 1 for exactly this one cycle; FSM SHALL then return to INICIAL.
- REQ-014 Latency: with the start-sampling edge as edge 0, pronto SHALL be high in the cycle after edge W+1 (cycle W+1), i.e. W+2 cycles start-to-result.
- REQ-015 binary SHALL hold its last value until the next FIM; it SHALL NOT change during DESLOCA.
- REQ-016 start asserted in DESLOCA or FIM SHALL be ignored, with no restart and no queuing.
- REQ-017 bcd changes after the load edge SHALL NOT affect the conversion in progress.
- REQ-018 The result SHALL be exact when W >= ceil(log2(10^D)); otherwise the low W bits of the value SHALL be produced.
- REQ-019 The counter SHALL be ceil(log2(W+1)) bits wide and SHALL NOT wrap within a conversion.

Reset
- REQ-020 While reset=1, asynchronously: FSM SHALL be in INICIAL, binary=0, pronto=0, bcd_reg=0, bin_reg=0, counter=0.
- REQ-021 Reset during DESLOCA SHALL abort the conversion with no pronto pulse; the first start after release SHALL begin a fresh conversion.
- REQ-022 start coincident with the reset-release edge SHALL be ignored if reset is still high at that edge.

Configuration
- REQ-023 Macro BCD2BIN_ERRO_EN SHALL, when defined, add port erro  output  1:
  - set at load when any input digit > 9;
  - at FIM, forces binary=0 while erro=1;
  - erro held until the next accepted start; reset value 0.
- REQ-024 Without BCD2BIN_ERRO_EN there SHALL be no erro port; invalid digits SHALL give an unspecified binary value with unchanged pronto timing.

Verification
- REQ-025 Defaults; bcd=8'h42, start pulse -> pronto high exactly 8 cycles after the start edge, binary=7'd42.
- REQ-026 bcd=8'h99 -> binary=7'd99; bcd=8'h00 -> binary=7'd0; both with pronto one cycle wide.
- REQ-027 start at 8'h15, second start pulse at cycle 3 with bcd=8'h77 -> single pronto, binary=7'd15, second start ignored.
- REQ-028 Reset pulse at cycle 4 of a conversion of 8'h63 -> no pronto, binary=0; next start with 8'h63 -> binary=7'd63.
- REQ-029 With BCD2BIN_ERRO_EN, bcd=8'h3A -> erro=1, binary=0 at pronto; next start with 8'h21 -> erro=0, binary=7'd21.
- REQ-030 W=14, N=16; bcd=16'h9999 -> binary=14'd9999, pronto 15 cycles after the start edge.
